// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic-computing pipeline: state encoding and default window size.
package stoch_pkg;

  localparam int unsigned DEFAULT_WIN_LOG2 = 8;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ACCUM = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StAccum = ST_ACCUM
  } state_e;

endpackage

// File: rtl/sn_win_ctr.sv
// Window counter pair: counted samples and ones, with clear, enable and terminal-count flag.
module sn_win_ctr
  import stoch_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = DEFAULT_WIN_LOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic                bit_in,
  output logic [WIN_LOG2-1:0] ones,
  output logic                tc
);

  logic [WIN_LOG2-1:0] samples_q;
  logic [WIN_LOG2-1:0] ones_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samples_q <= '0;
      ones_q    <= '0;
    end else if (clr) begin
      samples_q <= '0;
      ones_q    <= '0;
    end else if (en) begin
      samples_q <= samples_q + 1'b1;
      ones_q    <= ones_q + {{(WIN_LOG2-1){1'b0}}, bit_in};
    end
  end

  // Terminal count: the next counted sample is the last of the window.
  assign tc   = &samples_q;
  assign ones = ones_q;

endmodule

// File: rtl/sn2bin_window.sv
// Stochastic-to-binary decoder: counts ones over 2^WIN_LOG2 valid samples, result under valid/ready.
module sn2bin_window
  import stoch_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = DEFAULT_WIN_LOG2,
  parameter int unsigned OUT_W    = WIN_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             continuous,
  input  logic             sn_in,
  input  logic             sn_valid,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] bin_out,
  output logic             sat,
  output logic             overrun,
  output logic             busy
);

  state_e state_q, state_d;

  logic                ctr_clr;
  logic                ctr_en;
  logic                load;
  logic                clr_overrun;
  logic [WIN_LOG2-1:0] ones;
  logic                tc;
  logic [WIN_LOG2:0]   final_cnt;
  logic                full;

  logic [OUT_W-1:0]    bin_q;
  logic                sat_q;
  logic                valid_q;
  logic                overrun_q;

  sn_win_ctr #(
    .WIN_LOG2(WIN_LOG2)
  ) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .bit_in(sn_in),
    .ones  (ones),
    .tc    (tc)
  );

  // One bit wider so an all-ones window is distinguishable from zero.
  assign final_cnt = {1'b0, ones} + {{WIN_LOG2{1'b0}}, sn_in};
  assign full      = final_cnt[WIN_LOG2];

  always_comb begin
    state_d     = state_q;
    ctr_clr     = 1'b0;
    ctr_en      = 1'b0;
    load        = 1'b0;
    clr_overrun = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d     = StAccum;
          ctr_clr     = 1'b1;
          clr_overrun = 1'b1;
        end
      end
      StAccum: begin
        if (abort) begin
          state_d = StIdle;
          ctr_clr = 1'b1;
        end else if (sn_valid) begin
          if (tc) begin
            load    = 1'b1;
            ctr_clr = 1'b1;
            if (!continuous) begin
              state_d = StIdle;
            end
          end else begin
            ctr_en = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q     <= '0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load) begin
        bin_q   <= full ? '1 : final_cnt[OUT_W-1:0];
        sat_q   <= full;
        valid_q <= 1'b1;
        // Overwriting a result nobody has taken yet.
        if (valid_q && !out_ready) begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
      if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign out_valid = valid_q;
  assign bin_out   = bin_q;
  assign sat       = sat_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == StAccum);

endmodule

// File: tb/tb_sn2bin_window.sv
// Randomised scoreboard bench for sn2bin_window against a window-level behavioural model.
module tb_sn2bin_window;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, continuous, sn_in, sn_valid, out_ready;
  logic       out_valid, sat, overrun, busy;
  logic [7:0] bin_out;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit         m_in_win, m_pending, m_overrun;
  int         m_cnt, m_ones;
  logic [8:0] exp_q[$];  // {sat, bin}

  int rdy_mode;  // 0: never ready, 1: always, 2: random, 3: only when forced
  bit cont_v;
  bit pat[256];

  sn2bin_window #(
    .WIN_LOG2(8),
    .OUT_W   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .continuous(continuous),
    .sn_in     (sn_in),
    .sn_valid  (sn_valid),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .bin_out   (bin_out),
    .sat       (sat),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: status against the model every cycle, results popped on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_pending});
      chk("busy", {31'd0, busy}, {31'd0, m_in_win});
      chk("overrun", {31'd0, overrun}, {31'd0, m_overrun});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("bin_out", {24'd0, bin_out}, {24'd0, e[7:0]});
          chk("sat", {31'd0, sat}, {31'd0, e[8]});
        end
      end
    end
  end

  task automatic model_reset();
    m_in_win  = 0;
    m_pending = 0;
    m_overrun = 0;
    m_cnt     = 0;
    m_ones    = 0;
    exp_q.delete();
  endtask

  // Behaviour at one clock edge, stated in terms of windows of 256 counted samples.
  task automatic model_edge(input bit st, input bit ab, input bit b, input bit v, input bit r,
                            input bit c);
    bit         done;
    int         fin;
    logic [8:0] res;
    done = 0;
    fin  = 0;
    if (m_in_win) begin
      if (ab) begin
        m_in_win = 0;
        m_cnt    = 0;
        m_ones   = 0;
      end else if (v) begin
        m_ones += int'(b);
        m_cnt++;
        if (m_cnt == 256) begin
          done   = 1;
          fin    = m_ones;
          m_cnt  = 0;
          m_ones = 0;
          if (!c) m_in_win = 0;
        end
      end
    end else if (st && !ab) begin
      m_in_win  = 1;
      m_cnt     = 0;
      m_ones    = 0;
      m_overrun = 0;
    end
    if (done) begin
      if (m_pending && !r) begin
        m_overrun = 1;
        void'(exp_q.pop_back());
      end
      res = (fin >= 256) ? 9'h1FF : {1'b0, fin[7:0]};
      exp_q.push_back(res);
      m_pending = 1;
    end else if (m_pending && r) begin
      m_pending = 0;
    end
  endtask

  task automatic step(input bit st, input bit ab, input bit b, input bit v, input bit force_rdy);
    bit r;
    case (rdy_mode)
      1:       r = 1;
      2:       r = 1'($urandom_range(0, 1));
      default: r = 0;
    endcase
    if (force_rdy) r = 1;
    start      = st;
    abort      = ab;
    sn_in      = b;
    sn_valid   = v;
    out_ready  = r;
    continuous = cont_v;
    @(posedge clk);
    model_edge(st, ab, b, v, r, cont_v);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'($urandom_range(0, 1)), 0, 0);
  endtask

  task automatic fill_pat(input int k);
    bit t;
    int j;
    for (int i = 0; i < 256; i++) pat[i] = (i < k);
    for (int i = 255; i > 0; i--) begin
      j      = int'($urandom_range(0, i));
      t      = pat[i];
      pat[i] = pat[j];
      pat[j] = t;
    end
  endtask

  // gap_pct < 0: strict valid/invalid alternation; otherwise random invalid gaps.
  task automatic feed(input int from, input int to, input int gap_pct, input bit force_last);
    for (int i = from; i < to; i++) begin
      if (gap_pct >= 0) begin
        while (int'($urandom_range(0, 99)) < gap_pct)
          step(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 0, 0);
      end
      step(0, 0, pat[i], 1, force_last && (i == to - 1));
      if (gap_pct < 0) step(0, 0, 1'($urandom_range(0, 1)), 0, 0);
    end
  endtask

  task automatic async_reset();
    #2 rst = 1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bin_out", {24'd0, bin_out}, 32'd0);
    chk("rst_sat", {31'd0, sat}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; abort = 0; continuous = 0; sn_in = 0; sn_valid = 0; out_ready = 0;
    cont_v = 0;
    rdy_mode = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_bin_out", {24'd0, bin_out}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_sat", {31'd0, sat}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    // All ones saturates.
    fill_pat(256);
    step(1, 0, 0, 0, 0);
    feed(0, 256, 0, 0);
    idle(3);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // Alternating bits, result held under back-pressure.
    for (int i = 0; i < 256; i++) pat[i] = (i % 2 == 0);
    rdy_mode = 0;
    step(1, 0, 0, 0, 0);
    feed(0, 256, 0, 0);
    idle(10);
    chk("t2_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_hold_bin", {24'd0, bin_out}, 32'h80);
    rdy_mode = 1;
    idle(2);
    chk("t2_cleared", {31'd0, out_valid}, 32'd0);

    // Alternating sn_valid stretches the window to 512 clocks.
    fill_pat(64);
    rdy_mode = 2;
    step(1, 0, 0, 0, 0);
    feed(0, 256, -1, 0);
    rdy_mode = 1;
    idle(3);

    // Back-to-back windows with no consumer: second overwrites first.
    rdy_mode = 0;
    cont_v = 1;
    fill_pat(16);
    step(1, 0, 0, 0, 0);
    feed(0, 256, 20, 0);
    fill_pat(32);
    feed(0, 255, 20, 0);
    cont_v = 0;
    feed(255, 256, 0, 0);
    idle(2);
    chk("t4_overrun", {31'd0, overrun}, 32'd1);
    chk("t4_bin", {24'd0, bin_out}, 32'h20);
    rdy_mode = 1;
    idle(2);
    chk("t4_overrun_sticky", {31'd0, overrun}, 32'd1);
    rdy_mode = 0;
    step(1, 0, 0, 0, 0);
    chk("t4_overrun_cleared", {31'd0, overrun}, 32'd0);

    // Leave a result pending, then abort windows; result must survive.
    fill_pat(int'($urandom_range(0, 255)));
    feed(0, 256, 10, 0);
    step(1, 0, 0, 0, 0);
    feed(0, 100, 10, 0);
    step(1, 1, 1, 1, 0);
    chk("t5_abort_idle", {31'd0, busy}, 32'd0);
    chk("t5_abort_valid", {31'd0, out_valid}, 32'd1);
    step(1, 0, 0, 0, 0);
    fill_pat(200);
    feed(0, 255, 10, 0);
    step(0, 1, 1, 1, 0);  // abort beats completion
    idle(2);
    rdy_mode = 1;
    idle(2);

    // Asynchronous reset mid-window, then a clean window of 0x33 ones.
    step(1, 0, 0, 0, 0);
    fill_pat(128);
    feed(0, 50, 10, 0);
    async_reset();
    fill_pat(8'h33);
    step(1, 0, 0, 0, 0);
    feed(0, 256, 10, 0);
    idle(3);

    // Completion coincident with acceptance of a pending result.
    rdy_mode = 3;
    fill_pat(int'($urandom_range(0, 255)));
    step(1, 0, 0, 0, 0);
    feed(0, 256, 10, 0);
    step(1, 0, 0, 0, 0);
    fill_pat(int'($urandom_range(0, 255)));
    feed(0, 255, 10, 0);
    feed(255, 256, 0, 1);
    chk("t6_valid_stays", {31'd0, out_valid}, 32'd1);
    chk("t6_no_overrun", {31'd0, overrun}, 32'd0);
    rdy_mode = 1;
    idle(2);

    // Random windows with random gaps, consumer and continuous mode.
    rdy_mode = 2;
    for (int w = 0; w < 5; w++) begin
      cont_v = 1'($urandom_range(0, 1));
      fill_pat(int'($urandom_range(0, 256)));
      if (!m_in_win) step(1, 0, 0, 0, 0);
      feed(0, 256, 30, 0);
      idle(int'($urandom_range(0, 4)));
    end
    cont_v = 0;
    if (m_in_win) step(0, 1, 0, 0, 0);
    rdy_mode = 1;
    idle(4);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sn2bin_window.md
Name: sn2bin_window

Overview:
Stochastic-to-binary decoder that sits at the output end of the stochastic multiply pipeline. It counts ones in a unipolar stochastic bitstream over a fixed window of 2^WIN_LOG2 valid samples and presents the count as a binary value. The result is held under a valid/ready handshake. It is the inverse of the binary-to-stochastic generators and replaces ad-hoc free-running output counters.

Parameters:
WIN_LOG2, 8, log2 of the window length in counted samples (window = 256 samples).
OUT_W, WIN_LOG2, width of bin_out. Must equal WIN_LOG2.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a window when IDLE
abort  in  1  discards the current window and returns to IDLE
continuous  in  1  1 = back-to-back windows; 0 = single window then IDLE
sn_in  in  1  stochastic bit
sn_valid  in  1  sn_in is counted this cycle (output-gate qualifier)
out_ready  in  1  consumer accepts bin_out
out_valid  out  1  bin_out holds an unconsumed result
bin_out  out  OUT_W  ones count of the last completed window, saturated
sat  out  1  last result saturated (window was all ones)
overrun  out  1  sticky; a result was overwritten before acceptance
busy  out  1  state == ACCUM

Behaviour:
- Reset (async): state = IDLE, ones/sample counters = 0, bin_out = 0, out_valid = 0, sat = 0, overrun = 0, busy = 0.
- States: IDLE, ACCUM.
  - IDLE, start=1, abort=0: go to ACCUM and clear both counters.
  - ACCUM: start is ignored.
  - ACCUM, abort=1: go to IDLE and clear counters. The partial count is discarded. out_valid/bin_out are untouched.
  - abort has priority over start and over window completion in the same cycle.
- Counting happens in ACCUM only when sn_valid=1:
  - ones += sn_in
  - samples += 1
  - Cycles with sn_valid=0 freeze both counters and do not advance the window.
- Window completion is the cycle with sn_valid=1 and samples == 2^WIN_LOG2-1:
  - final = ones + sn_in, computed WIN_LOG2+1 bits wide.
  - bin_out <= (final == 2^WIN_LOG2) ? all-ones : final[OUT_W-1:0].
  - sat <= (final == 2^WIN_LOG2).
  - out_valid <= 1 on the next edge. Latency is 1 cycle from the last sample to out_valid.
  - continuous=1: stay in ACCUM with counters cleared. The next sample is counted in the following cycle, with no gap.
  - continuous=0: go to IDLE.
- Handshake:
  - out_valid=1 and out_ready=1 at an edge: the result is consumed and out_valid clears.
  - bin_out/sat hold while out_valid=1 and out_ready=0.
  - Completion with out_valid=1 and out_ready=0: the new result overwrites and overrun <= 1. overrun clears only on rst or on start accepted in IDLE.
  - Completion in the same cycle as out_ready=1: the new result loads, out_valid stays 1, no overrun.
- out_ready while out_valid=0: no effect.
- continuous is sampled at completion only. Changing it mid-window is legal.
- Counters are sized WIN_LOG2 bits (samples) and WIN_LOG2 bits (ones, pre-final). ones cannot overflow before the last sample.

Decomposition:
- Shared package (stoch_pkg): state encoding constants (ST_IDLE=0, ST_ACCUM=1) and the default WIN_LOG2.
- One natural sub-module: sn_win_ctr. It holds the samples/ones counter pair with clear, enable and a terminal-count flag. The parent owns the FSM, saturation, result register and handshake.

Test Plan:
- Reset, start, sn_valid=1, sn_in=1 for 256 cycles, continuous=0 -> bin_out=0xFF, sat=1, out_valid 1 cycle after the 256th sample, busy=0.
- Alternating sn_in 1,0 for 256 valid cycles -> bin_out=0x80, sat=0. out_ready held 0 for 10 cycles -> value holds, then clears on out_ready=1.
- sn_valid toggling 1,0; sn_in=1 only on valid cycles for 64 of 256 samples -> window spans 512 clocks, bin_out=0x40.
- continuous=1, out_ready=0, two windows (first 0x10, second 0x20 ones) -> bin_out=0x20, overrun=1. A later start in IDLE clears overrun.
- abort at sample 100, and separately rst asserted asynchronously mid-window -> abort: IDLE, out_valid unchanged; rst: all outputs 0 immediately. A subsequent full window of 0x33 ones yields bin_out=0x33.
- Completion cycle coincident with out_ready=1 on a pending result -> out_valid stays 1, bin_out takes the new value, overrun=0.
